// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory: default geometry and the
// dump sequencer state encoding.
package mem_ctrl_pkg;

  localparam int DEFAULT_DATA_SIZE = 32;
  localparam int DEFAULT_BANK_SIZE = 32;
  localparam int DEFAULT_REG_SIZE  = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

endpackage

// File: rtl/mem_dump_fsm.sv
// Sequencer for a full data-memory dump: walks every address, captures the
// registered read data and offers each word over a valid/ready handshake.
module mem_dump_fsm
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int BANK_SIZE = DEFAULT_BANK_SIZE,
  parameter int REG_SIZE  = DEFAULT_REG_SIZE
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_dump_start,
  input  logic                 i_dump_ready,
  input  logic [DATA_SIZE-1:0] i_mem_read_data,
  output logic                 o_dump_valid,
  output logic [DATA_SIZE-1:0] o_dump_data,
  output logic [REG_SIZE-1:0]  o_dump_addr,
  output logic                 o_dump_busy,
  output logic                 o_dump_done,
  output logic                 o_mem_read,
  output logic [REG_SIZE-1:0]  o_counter
);

  localparam logic [REG_SIZE-1:0] LAST_ADDR = REG_SIZE'(BANK_SIZE - 1);

  dump_state_e          state, state_next;
  logic [REG_SIZE-1:0]  counter, counter_next;
  logic                 capture;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      counter     <= '0;
      o_dump_data <= '0;
      o_dump_addr <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      if (capture) begin
        o_dump_data <= i_mem_read_data;
        o_dump_addr <= counter;
      end
    end
  end

  // NOTE: every signal driven here gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    capture      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_dump_start) begin
          counter_next = '0;
          state_next   = ST_READ;
        end
      end
      ST_READ: state_next = ST_WAIT;
      ST_WAIT: begin
        capture    = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (i_dump_ready) begin
          // Terminal count is tested before incrementing, so the counter never wraps.
          if (counter == LAST_ADDR) begin
            state_next = ST_DONE;
          end else begin
            counter_next = counter + REG_SIZE'(1);
            state_next   = ST_READ;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_dump_valid = (state == ST_SEND);
  assign o_dump_busy  = (state != ST_IDLE);
  assign o_dump_done  = (state == ST_DONE);
  assign o_mem_read   = (state == ST_READ);
  assign o_counter    = counter;

endmodule

// File: rtl/mem_data_ctrl.sv
// MEM-stage data memory access controller: the pipeline owns the port while
// idle, the dump sequencer owns it (and stalls the pipeline) otherwise.
module mem_data_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int BANK_SIZE = DEFAULT_BANK_SIZE,
  parameter int REG_SIZE  = DEFAULT_REG_SIZE
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_pipe_enable,
  input  logic                 i_pipe_write,
  input  logic                 i_pipe_read,
  input  logic [REG_SIZE-1:0]  i_pipe_addr,
  input  logic [DATA_SIZE-1:0] i_pipe_write_data,
  output logic [DATA_SIZE-1:0] o_pipe_read_data,
  output logic                 o_pipe_stall,
  input  logic                 i_dump_start,
  input  logic                 i_dump_ready,
  output logic                 o_dump_valid,
  output logic [DATA_SIZE-1:0] o_dump_data,
  output logic [REG_SIZE-1:0]  o_dump_addr,
  output logic                 o_dump_busy,
  output logic                 o_dump_done,
  output logic                 o_mem_enable,
  output logic                 o_mem_write,
  output logic                 o_mem_read,
  output logic [REG_SIZE-1:0]  o_mem_addr,
  output logic [DATA_SIZE-1:0] o_mem_write_data,
  input  logic [DATA_SIZE-1:0] i_mem_read_data
);

  logic                dump_read;
  logic [REG_SIZE-1:0] dump_counter;

  mem_dump_fsm #(
    .DATA_SIZE (DATA_SIZE),
    .BANK_SIZE (BANK_SIZE),
    .REG_SIZE  (REG_SIZE)
  ) u_dump_fsm (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_dump_start    (i_dump_start),
    .i_dump_ready    (i_dump_ready),
    .i_mem_read_data (i_mem_read_data),
    .o_dump_valid    (o_dump_valid),
    .o_dump_data     (o_dump_data),
    .o_dump_addr     (o_dump_addr),
    .o_dump_busy     (o_dump_busy),
    .o_dump_done     (o_dump_done),
    .o_mem_read      (dump_read),
    .o_counter       (dump_counter)
  );

  // Selection follows the registered busy flag, so a pipeline access in the
  // same cycle as the start request still reaches the memory.
  always_comb begin
    o_mem_enable     = i_pipe_enable;
    o_mem_write      = i_pipe_write;
    o_mem_read       = i_pipe_read;
    o_mem_addr       = i_pipe_addr;
    o_mem_write_data = i_pipe_write_data;
    if (o_dump_busy) begin
      o_mem_enable     = 1'b1;
      o_mem_write      = 1'b0;
      o_mem_read       = dump_read;
      o_mem_addr       = dump_counter;
      o_mem_write_data = '0;
    end
  end

  assign o_pipe_read_data = i_mem_read_data;
  assign o_pipe_stall     = o_dump_busy;

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Bench for mem_data_ctrl: behavioural memory, shadow-array model of memory
// contents, and a queue of expected dump beats snapshotted at each start.
module tb_mem_data_ctrl;

  localparam int DS = 32;
  localparam int BS = 32;
  localparam int RS = 5;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_pipe_enable, i_pipe_write, i_pipe_read;
  logic [RS-1:0] i_pipe_addr;
  logic [DS-1:0] i_pipe_write_data;
  logic [DS-1:0] o_pipe_read_data;
  logic          o_pipe_stall;
  logic          i_dump_start, i_dump_ready;
  logic          o_dump_valid;
  logic [DS-1:0] o_dump_data;
  logic [RS-1:0] o_dump_addr;
  logic          o_dump_busy, o_dump_done;
  logic          o_mem_enable, o_mem_write, o_mem_read;
  logic [RS-1:0] o_mem_addr;
  logic [DS-1:0] o_mem_write_data;
  logic [DS-1:0] i_mem_read_data;

  int checks = 0;
  int errors = 0;

  logic [DS-1:0] mem [BS];
  logic [DS-1:0] sh  [BS];

  typedef struct {
    int            addr;
    logic [DS-1:0] data;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic          en, we, rd;
    logic [RS-1:0] addr;
    logic [DS-1:0] wdata;
    logic          x_en, x_we, x_rd;
    logic [RS-1:0] x_addr;
    logic [DS-1:0] x_wdata;
  } vec_t;
  vec_t vecs[4];

  mem_data_ctrl #(.DATA_SIZE(DS), .BANK_SIZE(BS), .REG_SIZE(RS)) dut (
    .i_clock           (i_clock),
    .i_reset           (i_reset),
    .i_pipe_enable     (i_pipe_enable),
    .i_pipe_write      (i_pipe_write),
    .i_pipe_read       (i_pipe_read),
    .i_pipe_addr       (i_pipe_addr),
    .i_pipe_write_data (i_pipe_write_data),
    .o_pipe_read_data  (o_pipe_read_data),
    .o_pipe_stall      (o_pipe_stall),
    .i_dump_start      (i_dump_start),
    .i_dump_ready      (i_dump_ready),
    .o_dump_valid      (o_dump_valid),
    .o_dump_data       (o_dump_data),
    .o_dump_addr       (o_dump_addr),
    .o_dump_busy       (o_dump_busy),
    .o_dump_done       (o_dump_done),
    .o_mem_enable      (o_mem_enable),
    .o_mem_write       (o_mem_write),
    .o_mem_read        (o_mem_read),
    .o_mem_addr        (o_mem_addr),
    .o_mem_write_data  (o_mem_write_data),
    .i_mem_read_data   (i_mem_read_data)
  );

  always #5 i_clock = ~i_clock;

  // Registered read port that returns 0 when no read is issued.
  always @(posedge i_clock) begin
    if (o_mem_enable && o_mem_write) mem[o_mem_addr] <= o_mem_write_data;
    i_mem_read_data <= (o_mem_enable && o_mem_read) ? mem[o_mem_addr] : '0;
  end

  task automatic check(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic pipe_idle();
    i_pipe_enable = 0; i_pipe_write = 0; i_pipe_read = 0;
    i_pipe_addr = '0; i_pipe_write_data = '0;
  endtask

  task automatic pipe_store(input int a, input logic [DS-1:0] d);
    i_pipe_enable = 1; i_pipe_write = 1; i_pipe_read = 0;
    i_pipe_addr = RS'(a); i_pipe_write_data = d;
    sh[a] = d;
    tick();
    pipe_idle();
  endtask

  task automatic pipe_load_check(input int a);
    i_pipe_enable = 1; i_pipe_write = 0; i_pipe_read = 1;
    i_pipe_addr = RS'(a);
    tick();
    pipe_idle();
    check("pipe_load", o_pipe_read_data, sh[a]);
    check("pipe_stall_idle", {31'b0, o_pipe_stall}, 0);
  endtask

  // Runs one dump from the idle state. Expected beats come from the shadow
  // array; expected done cycle is 3 per word plus one, plus every cycle a
  // valid word waited on ready.
  task automatic run_dump(input bit rdy_random, input int bp_word, input int restart_word,
                          input int abort_word, input bit noise,
                          input bit co_store, input logic [DS-1:0] co_data);
    int cyc, waits, bp_left, seen_done;
    bit bp_used, restarted, rdy;
    exp_q.delete();
    i_dump_start = 1;
    if (co_store) begin
      i_pipe_enable = 1; i_pipe_write = 1; i_pipe_read = 0;
      i_pipe_addr = '0; i_pipe_write_data = co_data;
      sh[0] = co_data;
    end
    for (int k = 0; k < BS; k++) exp_q.push_back('{addr: k, data: sh[k]});
    #1;
    check("start_mux_write", {31'b0, o_mem_write}, {31'b0, co_store});
    tick();
    i_dump_start = 0;
    pipe_idle();
    cyc = 1; waits = 0; bp_left = 0; seen_done = 0; bp_used = 0; restarted = 0;
    while (seen_done == 0 && cyc < 600) begin
      if (noise) begin
        i_pipe_enable = 1'($urandom); i_pipe_write = 1'($urandom);
        i_pipe_read = 1'($urandom); i_pipe_addr = RS'($urandom);
        i_pipe_write_data = $urandom;
      end
      #1;
      check("dump_stall", {31'b0, o_pipe_stall}, 1);
      check("dump_no_write", {31'b0, o_mem_write}, 0);
      i_dump_start = 0;
      if (o_dump_done) begin
        seen_done = 1;
        check("done_after_all_beats", exp_q.size(), 0);
        check("done_cycle", cyc, 3 * BS + 1 + waits);
      end else if (o_dump_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          check("dump_addr", {27'b0, o_dump_addr}, exp_q[0].addr);
          check("dump_data", o_dump_data, exp_q[0].data);
          if (abort_word >= 0 && exp_q[0].addr == abort_word) begin
            i_reset = 0;
            tick();
            i_reset = 1;
            pipe_idle();
            check("abort_busy", {31'b0, o_dump_busy}, 0);
            check("abort_valid", {31'b0, o_dump_valid}, 0);
            check("abort_stall", {31'b0, o_pipe_stall}, 0);
            check("abort_done", {31'b0, o_dump_done}, 0);
            check("abort_data", o_dump_data, 0);
            for (int j = 0; j < 4; j++) begin
              tick();
              check("abort_no_done", {31'b0, o_dump_done}, 0);
            end
            return;
          end
          if (restart_word >= 0 && !restarted && exp_q[0].addr == restart_word) begin
            i_dump_start = 1;
            restarted = 1;
          end
          if (bp_word >= 0 && !bp_used && exp_q[0].addr == bp_word) begin
            bp_used = 1;
            bp_left = 5;
          end
          if (bp_left > 0) begin
            rdy = 0;
            bp_left--;
          end else begin
            rdy = rdy_random ? 1'($urandom) : 1'b1;
          end
          i_dump_ready = rdy;
          if (rdy) void'(exp_q.pop_front());
          else waits++;
        end
      end else begin
        i_dump_ready = rdy_random ? 1'($urandom) : 1'b1;
      end
      tick();
      cyc++;
    end
    if (seen_done == 0) check("dump_timeout", 0, 1);
    pipe_idle();
    i_dump_start = 0;
    i_dump_ready = 1;
    #1;
    check("done_one_cycle", {31'b0, o_dump_done}, 0);
    check("idle_after_done", {31'b0, o_dump_busy}, 0);
  endtask

  initial begin
    i_reset = 0; i_dump_start = 0; i_dump_ready = 1;
    pipe_idle();
    for (int k = 0; k < BS; k++) sh[k] = 'x;

    // Reset state.
    tick(); tick();
    check("rst_valid", {31'b0, o_dump_valid}, 0);
    check("rst_busy", {31'b0, o_dump_busy}, 0);
    check("rst_done", {31'b0, o_dump_done}, 0);
    check("rst_stall", {31'b0, o_pipe_stall}, 0);
    check("rst_data", o_dump_data, 0);
    check("rst_addr", {27'b0, o_dump_addr}, 0);
    check("rst_mem_en", {31'b0, o_mem_enable}, 0);
    i_reset = 1;
    tick();

    // Idle pass-through vectors.
    vecs[0] = '{1, 1, 0, 5'd3,  32'h1234_5678, 1, 1, 0, 5'd3,  32'h1234_5678};
    vecs[1] = '{1, 0, 1, 5'd31, 32'h0,         1, 0, 1, 5'd31, 32'h0};
    vecs[2] = '{0, 0, 0, 5'd12, 32'hA5A5_0000, 0, 0, 0, 5'd12, 32'hA5A5_0000};
    vecs[3] = '{1, 1, 0, 5'd0,  32'hFFFF_FFFF, 1, 1, 0, 5'd0,  32'hFFFF_FFFF};
    for (int i = 0; i < 4; i++) begin
      i_pipe_enable = vecs[i].en; i_pipe_write = vecs[i].we; i_pipe_read = vecs[i].rd;
      i_pipe_addr = vecs[i].addr; i_pipe_write_data = vecs[i].wdata;
      #1;
      check("vec_en", {31'b0, o_mem_enable}, {31'b0, vecs[i].x_en});
      check("vec_we", {31'b0, o_mem_write}, {31'b0, vecs[i].x_we});
      check("vec_rd", {31'b0, o_mem_read}, {31'b0, vecs[i].x_rd});
      check("vec_addr", {27'b0, o_mem_addr}, {27'b0, vecs[i].x_addr});
      check("vec_wdata", o_mem_write_data, vecs[i].x_wdata);
      if (vecs[i].en && vecs[i].we) sh[vecs[i].addr] = vecs[i].wdata;
      tick();
    end
    pipe_idle();

    // Store then load through the pipeline.
    pipe_store(7, 32'hDEAD_BEEF);
    pipe_load_check(7);
    check("load_deadbeef", o_pipe_read_data, 32'hDEAD_BEEF);

    // Preload and full dump with ready high.
    for (int k = 0; k < BS; k++) pipe_store(k, 32'h100 + k);
    run_dump(0, -1, -1, -1, 0, 0, '0);

    // Backpressure on word 3.
    run_dump(0, 3, -1, -1, 0, 0, '0);

    // Start coincident with a store to address 0.
    run_dump(0, -1, -1, -1, 0, 1, 32'hCAFE_0001);

    // Reset during word 10, then a fresh dump from address 0.
    run_dump(0, -1, -1, 10, 0, 0, '0);
    run_dump(0, -1, -1, -1, 0, 0, '0);

    // Start while busy is ignored.
    run_dump(0, -1, 5, -1, 0, 0, '0);

    // Randomized traffic with random ready and ignored pipeline noise.
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 20; n++) begin
        if ($urandom_range(0, 1) == 1) pipe_store($urandom_range(0, BS - 1), $urandom);
        else pipe_load_check($urandom_range(0, BS - 1));
      end
      run_dump(1, -1, -1, -1, 1, 0, '0);
      for (int k = 0; k < 4; k++) pipe_load_check($urandom_range(0, BS - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
